// File: rtl/param_stack_pkg.sv
// Shared types for the parameter stack: the per-cycle operation and its decode.
package param_stack_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_REJECT
    } op_e;

    // Push+pop on an empty stack degrades to a plain push; on a non-empty one it replaces the top.
    function automatic op_e decode_op(input logic push, input logic pop,
                                      input logic full, input logic empty);
        op_e op;
        op = OP_IDLE;
        if (push && pop)
            op = empty ? OP_PUSH : OP_REPLACE;
        else if (push)
            op = full ? OP_REJECT : OP_PUSH;
        else if (pop)
            op = empty ? OP_REJECT : OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/param_stack_mem.sv
// Stack storage: WIDTH x DEPTH, one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_stack.sv
// LIFO parameter stack with push/pop/replace decode and optional sticky error flags.
// Define PARAM_STACK_ERR_EN to build the OVERFLOW/UNDERFLOW flag logic; otherwise both read 0.
module param_stack
    import param_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clr_err,
    input  logic [WIDTH-1:0] i_data_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow,
    output logic             o_underflow
);

    logic [CW-1:0]    r_count;
    op_e              w_op;
    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic [AW-1:0]    w_top_addr;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_op       = decode_op(i_push, i_pop, w_full, w_empty);
    assign w_top_addr = AW'(r_count - CW'(1));

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_top_addr;
        case (w_op)
            OP_PUSH: begin
                w_we    = 1'b1;
                w_waddr = AW'(r_count);
            end
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_top_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (w_op == OP_PUSH)
            r_count <= r_count + CW'(1);
        else if (w_op == OP_POP)
            r_count <= r_count - CW'(1);
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_data_in),
        .i_raddr (w_top_addr),
        .o_rdata (w_rdata)
    );

    // Outputs depend only on the registered count, so reset clears them without a clock.
    assign o_data_out = w_empty ? '0 : w_rdata;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

`ifdef PARAM_STACK_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_ovf_evt = (w_op == OP_REJECT) && i_push;
    assign w_udf_evt = (w_op == OP_REJECT) && i_pop;

    // A new rejection on the same edge as CLR_ERR keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)
                r_overflow <= 1'b1;
            else if (i_clr_err)
                r_overflow <= 1'b0;
            if (w_udf_evt)
                r_underflow <= 1'b1;
            else if (i_clr_err)
                r_underflow <= 1'b0;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    logic w_unused_clr_err;
    assign w_unused_clr_err = i_clr_err;
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at WIDTH=8, DEPTH=4; expectations follow PARAM_STACK_ERR_EN.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef PARAM_STACK_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_push      (push),
        .i_pop       (pop),
        .i_clr_err   (clr_err),
        .i_data_in   (data_in),
        .o_data_out  (data_out),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (empty),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one op across one rising edge, leave inputs idle, sample 1 ns after the edge.
    task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d);
        push    = p;
        pop     = q;
        clr_err = c;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        data_in = '0;
    endtask

    logic [7:0] push_vals [4];

    initial begin
        push_vals[0] = 8'h11;
        push_vals[1] = 8'h22;
        push_vals[2] = 8'h33;
        push_vals[3] = 8'h44;

        rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, push_vals[i]);
            chk("push_count", 32'(count), 32'(i + 1));
            chk("push_dout", 32'(data_out), 32'(push_vals[i]));
        end
        chk("push_full", 32'(full), 1);
        chk("push_empty", 32'(empty), 0);

        step(1'b1, 1'b0, 1'b0, 8'h55);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_dout", 32'(data_out), 32'h44);
        chk("ovf_flag", 32'(overflow), 32'(ERR));

        step(1'b1, 1'b1, 1'b0, 8'h99);
        chk("repl_count", 32'(count), 4);
        chk("repl_dout", 32'(data_out), 32'h99);
        chk("repl_ovf_hold", 32'(overflow), 32'(ERR));

        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_ovf", 32'(overflow), 0);

        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop1_dout", 32'(data_out), 32'h33);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop2_dout", 32'(data_out), 32'h22);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop3_dout", 32'(data_out), 32'h11);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pop4_dout", 32'(data_out), 32'h00);
        chk("pop4_empty", 32'(empty), 1);
        chk("pop4_count", 32'(count), 0);

        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_flag", 32'(underflow), 32'(ERR));
        chk("udf_count", 32'(count), 0);

        step(1'b1, 1'b1, 1'b0, 8'h5A);
        chk("epp_count", 32'(count), 1);
        chk("epp_dout", 32'(data_out), 32'h5A);
        chk("epp_udf_hold", 32'(underflow), 32'(ERR));

        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("drain_empty", 32'(empty), 1);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("udf_beats_clr", 32'(underflow), 32'(ERR));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_udf", 32'(underflow), 0);

        step(1'b1, 1'b0, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 1'b0, 8'hB2);
        chk("pre_rst_count", 32'(count), 2);
        chk("pre_rst_dout", 32'(data_out), 32'hB2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_empty", 32'(empty), 1);
        chk("async_dout", 32'(data_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h77);
        chk("resume_count", 32'(count), 1);
        chk("resume_dout", 32'(data_out), 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (>=2, power of two not required).
REQ-003 SHALL have localparam CW = $clog2(DEPTH+1), the count width.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 PUSH  input  1  push request, sampled on CLK rise.
REQ-007 POP  input  1  pop request, sampled on CLK rise.
REQ-008 CLR_ERR  input  1  clears sticky error flags.
REQ-009 DATA_IN  input  WIDTH  data to push.
REQ-010 DATA_OUT  output  WIDTH  current top-of-stack.
REQ-011 COUNT  output  CW  number of valid entries.
REQ-012 FULL  output  1  COUNT == DEPTH.
REQ-013 EMPTY  output  1  COUNT == 0.
REQ-014 OVERFLOW  output  1  sticky: push rejected while full.
REQ-015 UNDERFLOW  output  1  sticky: pop rejected while empty.

Function
REQ-016 SHALL decode each cycle into exactly one op: IDLE, PUSH, POP, REPLACE, REJECT.
REQ-017 PUSH=1, POP=0, not full: SHALL write DATA_IN at index COUNT, COUNT+1.
REQ-018 PUSH=0, POP=1, not empty: SHALL discard top, COUNT-1; storage contents not required to be cleared.
REQ-019 PUSH=1, POP=1, not empty (incl. full): SHALL overwrite top with DATA_IN, COUNT unchanged (REPLACE), no error.
REQ-020 PUSH=1, POP=1, empty: SHALL perform a plain push, no error.
REQ-021 PUSH=1, POP=0, full: SHALL leave storage and COUNT unchanged (REJECT), set overflow event.
REQ-022 PUSH=0, POP=1, empty: SHALL leave state unchanged (REJECT), set underflow event.
REQ-023 DATA_OUT SHALL equal entry COUNT-1 when not empty, all-zero when empty; one-cycle latency: a push/replace at edge N is visible after edge N.
REQ-024 FULL, EMPTY, COUNT SHALL be registered or derived from registered COUNT only; no combinational path from PUSH/POP/DATA_IN to any output.
REQ-025 COUNT SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-026 RST_N low SHALL immediately force COUNT=0, EMPTY=1, FULL=0, DATA_OUT=0, OVERFLOW=0, UNDERFLOW=0, regardless of CLK.
REQ-027 Reset mid-operation SHALL discard all contents; storage array need not be reset.
REQ-028 Operations SHALL resume on the first rising edge after RST_N deasserts.

Configuration
REQ-029 Macro PARAM_STACK_ERR_EN SHALL compile in the error-flag logic.
REQ-030 With PARAM_STACK_ERR_EN: OVERFLOW/UNDERFLOW set on the edge of the rejected op, hold until CLR_ERR=1 at an edge; a coincident new error event wins over CLR_ERR.
REQ-031 Without PARAM_STACK_ERR_EN: OVERFLOW=UNDERFLOW=0 constantly, CLR_ERR ignored; stack behaviour otherwise identical (rejects still ignored).

Structure
REQ-032 Op enum (IDLE, PUSH, POP, REPLACE, REJECT) SHALL live in shared package param_stack_pkg.
REQ-033 Storage SHALL be sub-module stack_mem (WIDTH x DEPTH, one synchronous write port, one asynchronous read port), instantiated once.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset, push 0x11,0x22,0x33,0x44 -> COUNT 1..4, DATA_OUT=0x44, FULL=1 after fourth edge.
REQ-035 Full, push 0x55 -> COUNT=4, DATA_OUT=0x44, OVERFLOW=1 (0 without macro); CLR_ERR pulse -> OVERFLOW=0.
REQ-036 Full, PUSH+POP with 0x99 -> COUNT=4, DATA_OUT=0x99, OVERFLOW unchanged.
REQ-037 Pop 4 times -> DATA_OUT 0x33,0x22,0x11,0x00, EMPTY=1; fifth pop -> UNDERFLOW=1, COUNT=0.
REQ-038 Empty, PUSH+POP with 0x5A -> COUNT=1, DATA_OUT=0x5A, UNDERFLOW unchanged.
REQ-039 Push 2 entries, assert RST_N low between edges -> COUNT=0, EMPTY=1, DATA_OUT=0 without a clock edge.
